// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A one-requester arbiter still needs a 1-bit index port.
  function automatic int idx_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating priority pick: first set request at ptr, ptr+1, ..., wrapping to ptr-1.
module rr_arb_pick #(
  parameter int width = 8,
  parameter int IdxW  = 3
) (
  input  logic [width-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [width-1:0] pick
);

  int   j;
  logic found;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < width; k++) begin
      // Wrap by subtraction so non-power-of-two widths need no divider.
      j = int'(ptr) + k;
      if (j >= width) j = j - width;
      if (!found && req[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Define RR_ONEHOT_ARB_IDX_EN to register a binary grant index on gnt_idx_o.
module rr_onehot_arb
  import rr_arb_pkg::*;
#(
  parameter int width = 8,
  parameter int IdxW  = idx_w(width)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [width-1:0] req_i,
  output logic             gnt_valid_o,
  input  logic             gnt_ready_i,
  output logic [width-1:0] gnt_onehot_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  state_e           state_q, state_d;
  logic [width-1:0] gnt_q, gnt_d, pick;
  logic [IdxW-1:0]  ptr_q, ptr_d, ptr_next;
  logic             handshake;

  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [width-1:0] oh);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < width; i++) begin
      if (oh[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

`ifdef RR_ONEHOT_ARB_IDX_EN
  localparam logic [IdxW-1:0] LastIdx = IdxW'(width - 1);

  logic [IdxW-1:0] idx_q, idx_d;

  assign idx_d     = onehot_to_idx(gnt_d);
  assign ptr_next  = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
  assign gnt_idx_o = idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end
`else
  function automatic logic [width-1:0] rotl1(input logic [width-1:0] v);
    logic [width-1:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[(i + 1) % width] = v[i];
    end
    return r;
  endfunction

  // The bit after the current grant becomes the next highest priority.
  assign ptr_next  = onehot_to_idx(rotl1(gnt_q));
  assign gnt_idx_o = '0;
`endif

  assign handshake = (state_q == HOLD) && gnt_ready_i;
  // A handshake re-picks against the advanced pointer in the same cycle.
  assign ptr_d     = handshake ? ptr_next : ptr_q;

  rr_arb_pick #(
    .width (width),
    .IdxW  (IdxW)
  ) u_pick (
    .req  (req_i),
    .ptr  (ptr_d),
    .pick (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = pick;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (|req_i) begin
            gnt_d = pick;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_valid_o  = (state_q == HOLD);
  assign gnt_onehot_o = gnt_q;

endmodule
